// File: rtl/i2c_apb_requester.sv
// i2c_apb_requester
// APB initiator that turns single valid/ready register commands into APB
// SETUP/ACCESS transfers toward the APB-to-I2C core. Every command returns
// exactly one response. Accesses outside the core's register map, and
// transfers that never see pready, come back with rsp_err set.
//
// Ports:
//   pclk, preset                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_write/cmd_addr/cmd_wdata    command fields
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata/rsp_err               response fields
//   pselx/penable/pwrite/paddr/pwdata/prdata/pready   APB initiator side
module i2c_apb_requester #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  pselx,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   wait_cnt_r;
  logic            cmd_fire_s;

  // Register map of the I2C core: writes to 2/4/6, reads from 3/5 only.
  function automatic logic is_legal(input logic wr, input logic [ADDR_WIDTH-1:0] addr);
    logic ok;
    case (addr)
      ADDR_WIDTH'(2), ADDR_WIDTH'(4), ADDR_WIDTH'(6): ok = wr;
      ADDR_WIDTH'(3), ADDR_WIDTH'(5):                ok = ~wr;
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Gated by preset so no command can be taken during a reset cycle.
  assign cmd_ready  = (state_r == IDLE) && !preset;
  assign cmd_fire_s = cmd_valid && cmd_ready;

  // Request FSM with all APB and response outputs registered.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_r    <= IDLE;
      wait_cnt_r <= '0;
      pselx      <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_fire_s) begin
            if (is_legal(cmd_write, cmd_addr)) begin
              pwrite  <= cmd_write;
              paddr   <= cmd_addr;
              pwdata  <= cmd_wdata;
              pselx   <= 1'b1;
              state_r <= SETUP;
            end else begin
              // Illegal access is answered directly without touching the bus.
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state_r   <= RESP;
            end
          end
        end
        SETUP: begin
          penable    <= 1'b1;
          wait_cnt_r <= '0;
          state_r    <= ACCESS;
        end
        ACCESS: begin
          // pready is checked first so a completion in the last allowed
          // cycle wins over the timeout.
          if (pready) begin
            pselx     <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= pwrite ? '0 : prdata;
            state_r   <= RESP;
          end else if (wait_cnt_r == CW'(TIMEOUT - 1)) begin
            pselx     <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state_r   <= RESP;
          end else begin
            wait_cnt_r <= wait_cnt_r + CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          pselx     <= 1'b0;
          penable   <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_apb_requester.sv
module tb_i2c_apb_requester;

  localparam int TO = 16;

  logic       pclk = 1'b0;
  logic       preset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_rdata;
  logic       pselx, penable, pwrite;
  logic [7:0] paddr, pwdata, prdata;
  logic       pready;

  int n_tests = 0;
  int n_fail  = 0;

  i2c_apb_requester #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .pselx(pselx), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    int         waits;
    logic [7:0] rd;
    int         hold;
    logic       e_err;
    logic [7:0] e_rd;
    int         e_lat;
    int         e_pen;
    int         e_psel;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model straight from the register map and timing rules.
  function automatic void model(input logic w, input logic [7:0] a, input int waits,
                                input logic [7:0] rd, output logic e_err, output logic [7:0] e_rd,
                                output int e_lat, output int e_pen, output int e_psel);
    logic legal;
    legal = w ? (a == 8'd2 || a == 8'd4 || a == 8'd6) : (a == 8'd3 || a == 8'd5);
    if (!legal) begin
      e_err = 1'b1; e_rd = 8'h00; e_lat = 1; e_pen = 0; e_psel = 0;
    end else if (waits < TO) begin
      e_err = 1'b0; e_rd = w ? 8'h00 : rd; e_lat = 3 + waits; e_pen = waits + 1; e_psel = waits + 2;
    end else begin
      e_err = 1'b1; e_rd = 8'h00; e_lat = 2 + TO; e_pen = TO; e_psel = TO + 1;
    end
  endfunction

  // Issue one command with an APB responder inserting 'waits' wait states,
  // then hold off rsp_ready for 'hold' cycles and check everything.
  task automatic run_cmd(input string tag, input logic w, input logic [7:0] a, input logic [7:0] d,
                         input int waits, input logic [7:0] rd, input int hold,
                         input logic e_err, input logic [7:0] e_rd, input int e_lat,
                         input int e_pen, input int e_psel);
    int cyc, acc, pen_c, psel_c, lat;
    logic apb_ok, stable_ok, got_err, done;
    logic [7:0] got_rd;
    cyc = 0; acc = 0; pen_c = 0; psel_c = 0; lat = -1;
    apb_ok = 1'b1; stable_ok = 1'b1; got_err = 1'bx; got_rd = 8'hxx; done = 1'b0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    rsp_ready = (hold == 0); pready = 1'b0; prdata = rd;
    @(negedge pclk);
    chk({tag, " cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    @(posedge pclk); #1;
    cmd_valid = 1'b0; cmd_addr = 8'hEE; cmd_wdata = 8'hEE; cmd_write = ~w;
    cyc = 1;
    while (!done && cyc < 64) begin
      if (penable) begin
        acc++;
        pready = (acc == waits + 1);
      end else begin
        pready = 1'b0;
      end
      @(negedge pclk);
      if (pselx) begin
        psel_c++;
        if (paddr !== a || pwrite !== w || (w && pwdata !== d)) apb_ok = 1'b0;
      end
      if (penable) pen_c++;
      if ((penable && !pselx) || (penable && cyc == 1)) apb_ok = 1'b0;
      if (rsp_valid) begin
        lat = cyc; got_err = rsp_err; got_rd = rsp_rdata; done = 1'b1;
      end else begin
        @(posedge pclk); #1;
        cyc++;
      end
    end
    pready = 1'b0;
    chk({tag, " latency"}, lat, e_lat);
    chk({tag, " rsp_err"}, {31'd0, got_err}, {31'd0, e_err});
    chk({tag, " rsp_rdata"}, {24'd0, got_rd}, {24'd0, e_rd});
    chk({tag, " penable_cycles"}, pen_c, e_pen);
    chk({tag, " pselx_cycles"}, psel_c, e_psel);
    chk({tag, " apb_signals"}, {31'd0, apb_ok}, 32'd1);
    if (done) begin
      for (int k = 0; k < hold; k++) begin
        @(posedge pclk); #1;
        if (k == hold - 1) rsp_ready = 1'b1;
        @(negedge pclk);
        if (!rsp_valid || rsp_err !== got_err || rsp_rdata !== got_rd || cmd_ready) stable_ok = 1'b0;
      end
      if (hold > 0) chk({tag, " rsp_hold_stable"}, {31'd0, stable_ok}, 32'd1);
      @(posedge pclk); #1;
      @(negedge pclk);
      chk({tag, " post_handshake"}, {30'd0, cmd_ready, rsp_valid}, 32'b10);
      @(posedge pclk); #1;
    end
    rsp_ready = 1'b1;
  endtask

  initial begin
    logic       rw, e_err;
    logic [7:0] ra, rdv, rd_exp;
    int         rwait, rhold, e_lat, e_pen, e_psel;
    logic       rst_ok;

    //          w     a      d      waits rd     hold err   e_rd   lat      pen  psel
    tbl[0] = '{1'b1, 8'd2, 8'h5A, 0,    8'h00, 0,   1'b0, 8'h00, 3,       1,   2};
    tbl[1] = '{1'b0, 8'd3, 8'h00, 2,    8'hC3, 0,   1'b0, 8'hC3, 5,       3,   4};
    tbl[2] = '{1'b0, 8'd4, 8'h00, 0,    8'h00, 0,   1'b1, 8'h00, 1,       0,   0};
    tbl[3] = '{1'b1, 8'd5, 8'h12, 0,    8'h00, 0,   1'b1, 8'h00, 1,       0,   0};
    tbl[4] = '{1'b1, 8'd7, 8'h34, 0,    8'h00, 0,   1'b1, 8'h00, 1,       0,   0};
    tbl[5] = '{1'b0, 8'd5, 8'h00, TO,   8'hAB, 0,   1'b1, 8'h00, TO + 2,  TO,  TO + 1};
    tbl[6] = '{1'b0, 8'd3, 8'h00, TO-1, 8'h99, 0,   1'b0, 8'h99, TO + 2,  TO,  TO + 1};
    tbl[7] = '{1'b1, 8'd4, 8'h11, 1,    8'h00, 5,   1'b0, 8'h00, 4,       2,   3};
    tbl[8] = '{1'b0, 8'd5, 8'h00, 0,    8'h6D, 5,   1'b0, 8'h6D, 3,       1,   2};

    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    rsp_ready = 1'b1; prdata = 8'h00; pready = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    @(negedge pclk);
    chk("reset cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("reset outputs", {8'd0, pselx, penable, pwrite, rsp_valid, rsp_err, 3'd0, paddr, pwdata},
        32'd0);
    chk("reset rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    @(posedge pclk); #1;
    preset = 1'b0;
    @(negedge pclk);
    chk("after reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge pclk); #1;

    for (int i = 0; i < 9; i++) begin
      run_cmd($sformatf("vec%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].waits, tbl[i].rd,
              tbl[i].hold, tbl[i].e_err, tbl[i].e_rd, tbl[i].e_lat, tbl[i].e_pen, tbl[i].e_psel);
    end

    // Reset pulsed in the middle of an ACCESS phase.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'd2; cmd_wdata = 8'h3C; pready = 1'b0;
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    @(posedge pclk); #1;
    @(negedge pclk);
    chk("pre_reset access", {30'd0, pselx, penable}, 32'b11);
    @(posedge pclk); #1;
    preset = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0;
    @(negedge pclk);
    chk("reset_mid pselx_penable", {30'd0, pselx, penable}, 32'b00);
    rst_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge pclk); #1;
      @(negedge pclk);
      if (rsp_valid || pselx || !cmd_ready) rst_ok = 1'b0;
    end
    chk("reset_mid no_response", {31'd0, rst_ok}, 32'd1);
    @(posedge pclk); #1;
    run_cmd("after_reset write6", 1'b1, 8'd6, 8'hA5, 1, 8'h00, 0, 1'b0, 8'h00, 4, 2, 3);

    // Randomised commands against the reference model.
    for (int i = 0; i < 40; i++) begin
      rw    = 1'($urandom_range(0, 1));
      ra    = 8'($urandom_range(0, 9));
      if (i % 8 == 7) ra = 8'($urandom_range(0, 255));
      rdv   = 8'($urandom_range(0, 255));
      rwait = $urandom_range(0, 19);
      rhold = $urandom_range(0, 3);
      model(rw, ra, rwait, rdv, e_err, rd_exp, e_lat, e_pen, e_psel);
      run_cmd($sformatf("rnd%0d", i), rw, ra, rdv ^ 8'h5F, rwait, rdv, rhold,
              e_err, rd_exp, e_lat, e_pen, e_psel);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
